// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single dcache port between the instruction-fetch unit (IF) and
//   the load/store unit (LS). A grant is registered in IDLE and held until the
//   owner completes (mem_ready while valid), withdraws its request, or the
//   watchdog expires. Only the owner sees mem_ready / mem_rdata.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width (byte-enable width is DATA_W/8)
//   TIMEOUT  max grant cycles waiting for mem_ready; 0 disables the watchdog
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   if_valid/if_addr                fetch request (read only)
//   if_ready/if_rdata               fetch completion and read data
//   ls_valid/ls_addr/ls_wdata       LSU request
//   ls_byte_enable                  store lanes, all-zero means load
//   ls_ready/ls_rdata               LSU completion and read data
//   mem_valid/mem_addr/mem_wdata    request towards the dcache
//   mem_byte_enable                 lanes towards the dcache
//   mem_ready/mem_rdata             dcache completion pulse and read data
//   err                             one-cycle pulse on watchdog expiry
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: contention goes to the requester that did not
//                       own the port last. Undefined: LS always wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_valid,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_byte_enable,
  output logic                  ls_ready,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_byte_enable,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err
);

  localparam int CNT_W = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2
  } state_t;

  state_t             state;
  logic               last_owner_ls;
  logic [CNT_W-1:0]   wait_cnt;

  logic               owner_valid;
  logic               done;
  logic               timeout;
  logic               pick_ls;

  // Arbitration decision, only consulted in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    pick_ls = ls_valid;
    if (ls_valid && if_valid) begin
      pick_ls = !last_owner_ls;
    end
  end
`else
  // Fixed priority: LS wins contention; last_owner is kept but not consulted.
  logic last_owner_unused;
  assign last_owner_unused = last_owner_ls;
  assign pick_ls = ls_valid;
`endif

  always_comb begin
    owner_valid = 1'b0;
    case (state)
      GRANT_IF: owner_valid = if_valid;
      GRANT_LS: owner_valid = ls_valid;
      default:  owner_valid = 1'b0;
    endcase
  end

  assign done    = owner_valid && mem_ready;
  // Completion in the last watchdog cycle takes precedence over expiry.
  assign timeout = WD_EN && owner_valid && !mem_ready && (wait_cnt == TO_LAST);

  // State, ownership history and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_owner_ls <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (if_valid || ls_valid) begin
            state <= pick_ls ? GRANT_LS : GRANT_IF;
          end
        end
        GRANT_IF, GRANT_LS: begin
          if (!owner_valid || done || timeout) begin
            state         <= IDLE;
            last_owner_ls <= (state == GRANT_LS);
            wait_cnt      <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Port muxing towards the cache and completion routing back to the owner.
  always_comb begin
    mem_valid       = owner_valid;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    if_ready        = 1'b0;
    if_rdata        = '0;
    ls_ready        = 1'b0;
    ls_rdata        = '0;
    err             = timeout;
    case (state)
      GRANT_IF: begin
        mem_addr = if_addr;
        if (done) begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end
      end
      GRANT_LS: begin
        mem_addr        = ls_addr;
        mem_wdata       = ls_wdata;
        mem_byte_enable = ls_byte_enable;
        if (done) begin
          ls_ready = 1'b1;
          ls_rdata = mem_rdata;
        end
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        ls_valid;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_byte_enable;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_byte_enable(ls_byte_enable), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if_valid = 1'b0; if_addr = '0;
    ls_valid = 1'b0; ls_addr = '0; ls_wdata = '0; ls_byte_enable = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    tick;
    rst_n = 1'b0;
    clear_inputs();
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if_valid = 1'b1; if_addr = 32'h10; ls_valid = 1'b1; ls_addr = 32'h20;
    ls_wdata = 32'hFFFF_FFFF; ls_byte_enable = 4'hF; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick; tick;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%0h exp=0", mem_valid); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (mem_byte_enable !== 4'h0) begin failures++; $display("FAIL rst_mem_be got=%0h exp=0", mem_byte_enable); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL rst_if_ready got=%0h exp=0", if_ready); end
    checks++; if (ls_ready !== 1'b0) begin failures++; $display("FAIL rst_ls_ready got=%0h exp=0", ls_ready); end
    checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata got=%0h exp=0", if_rdata); end
    checks++; if (ls_rdata !== 32'h0) begin failures++; $display("FAIL rst_ls_rdata got=%0h exp=0", ls_rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch;
    tick;
    if_valid = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL sf_idle_valid got=%0h exp=0", mem_valid); end
    tick;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL sf_grant_valid got=%0h exp=1", mem_valid); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL sf_addr got=%0h exp=100", mem_addr); end
    checks++; if (mem_byte_enable !== 4'h0) begin failures++; $display("FAIL sf_be got=%0h exp=0", mem_byte_enable); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL sf_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL sf_early_ready got=%0h exp=0", if_ready); end
    tick;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || if_ready !== 1'b0) begin failures++; $display("FAIL sf_wait got=%0h/%0h exp=1/0", mem_valid, if_ready); end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL sf_if_ready got=%0h exp=1", if_ready); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sf_if_rdata got=%0h exp=deadbeef", if_rdata); end
    checks++; if (ls_ready !== 1'b0 || ls_rdata !== 32'h0) begin failures++; $display("FAIL sf_ls_quiet got=%0h/%0h exp=0/0", ls_ready, ls_rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL sf_err got=%0h exp=0", err); end
    tick;
    clear_inputs();
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL sf_after got=%0h/%0h exp=0/0", mem_valid, if_ready); end
  endtask

  task automatic test_ls_store;
    tick;
    ls_valid = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_byte_enable = 4'b1100;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || ls_ready !== 1'b0) begin failures++; $display("FAIL st_idle got=%0h/%0h exp=0/0", mem_valid, ls_ready); end
    tick;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL st_valid got=%0h exp=1", mem_valid); end
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL st_addr got=%0h exp=200", mem_addr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL st_wdata got=%0h exp=12345678", mem_wdata); end
    checks++; if (mem_byte_enable !== 4'b1100) begin failures++; $display("FAIL st_be got=%0h exp=c", mem_byte_enable); end
    checks++; if (ls_ready !== 1'b1 || ls_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL st_ls_ready got=%0h/%0h exp=1/cafe0001", ls_ready, ls_rdata); end
    checks++; if (if_ready !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL st_if_quiet got=%0h/%0h exp=0/0", if_ready, if_rdata); end
    tick;
    clear_inputs();
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || ls_ready !== 1'b0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL st_after got=%0h/%0h/%0h exp=0/0/0", mem_valid, ls_ready, mem_wdata); end
  endtask

  task automatic test_contention;
    logic [3:0] order_ls;
    logic       grant;
    logic       exp_ls;
`ifdef ARB_ROUND_ROBIN_EN
    order_ls = 4'b0101;
`else
    order_ls = 4'b1111;
`endif
    do_reset();
    if_valid = 1'b1; if_addr = 32'h180;
    ls_valid = 1'b1; ls_addr = 32'h280;
    mem_ready = 1'b1; mem_rdata = 32'h0000_ABCD;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      @(negedge clk);
      grant  = (i % 2) == 1;
      exp_ls = order_ls[i / 2];
      checks++; if (mem_valid !== grant) begin failures++; $display("FAIL ct_valid c%0d got=%0h exp=%0h", i, mem_valid, grant); end
      checks++; if (ls_ready !== (grant && exp_ls)) begin failures++; $display("FAIL ct_ls_ready c%0d got=%0h exp=%0h", i, ls_ready, grant && exp_ls); end
      checks++; if (if_ready !== (grant && !exp_ls)) begin failures++; $display("FAIL ct_if_ready c%0d got=%0h exp=%0h", i, if_ready, grant && !exp_ls); end
      checks++; if (mem_addr !== (grant ? (exp_ls ? 32'h280 : 32'h180) : 32'h0)) begin failures++; $display("FAIL ct_addr c%0d got=%0h", i, mem_addr); end
    end
    tick;
    clear_inputs();
  endtask

  task automatic test_withdrawal;
    do_reset();
    ls_valid = 1'b1; ls_addr = 32'h240;
    tick;
    if_valid = 1'b1; if_addr = 32'h140;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h240) begin failures++; $display("FAIL wd_grant got=%0h/%0h exp=1/240", mem_valid, mem_addr); end
    tick;
    ls_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_77EE;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL wd_drop got=%0h exp=0", mem_valid); end
    checks++; if (ls_ready !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL wd_no_ready got=%0h/%0h exp=0/0", ls_ready, if_ready); end
    tick;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL wd_idle got=%0h exp=0", mem_valid); end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'h0000_55AA;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h140) begin failures++; $display("FAIL wd_if_grant got=%0h/%0h exp=1/140", mem_valid, mem_addr); end
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0000_55AA || ls_ready !== 1'b0) begin failures++; $display("FAIL wd_if_done got=%0h/%0h/%0h exp=1/55aa/0", if_ready, if_rdata, ls_ready); end
    tick;
    clear_inputs();
  endtask

  task automatic test_watchdog;
    do_reset();
    if_valid = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_idle_err got=%0h exp=0", err); end
    for (int j = 0; j < 4; j++) begin
      tick;
      @(negedge clk);
      checks++; if (err !== (j == 3)) begin failures++; $display("FAIL to_err g%0d got=%0h exp=%0h", j, err, j == 3); end
      checks++; if (mem_valid !== 1'b1 || if_ready !== 1'b0) begin failures++; $display("FAIL to_wait g%0d got=%0h/%0h exp=1/0", j, mem_valid, if_ready); end
    end
    tick;
    if_valid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || mem_valid !== 1'b0) begin failures++; $display("FAIL to_after got=%0h/%0h exp=0/0", err, mem_valid); end
    tick;
    if_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      if (j == 3) begin mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D; end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to2_err g%0d got=%0h exp=0", j, err); end
      checks++; if (if_ready !== (j == 3)) begin failures++; $display("FAIL to2_ready g%0d got=%0h exp=%0h", j, if_ready, j == 3); end
    end
    checks++; if (if_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL to2_rdata got=%0h exp=badf00d", if_rdata); end
    tick;
    clear_inputs();
    @(negedge clk);
    checks++; if (err !== 1'b0 || mem_valid !== 1'b0) begin failures++; $display("FAIL to2_after got=%0h/%0h exp=0/0", err, mem_valid); end
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    ls_valid = 1'b1; ls_addr = 32'h280; mem_ready = 1'b1; mem_rdata = 32'h0000_1111;
    tick;
    @(negedge clk);
    checks++; if (ls_ready !== 1'b1) begin failures++; $display("FAIL rm_pre_ls got=%0h exp=1", ls_ready); end
    tick;
    ls_valid = 1'b0; mem_ready = 1'b0; if_valid = 1'b1; if_addr = 32'h400;
    tick;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h400) begin failures++; $display("FAIL rm_grant got=%0h/%0h exp=1/400", mem_valid, mem_addr); end
    tick;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555; ls_valid = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rm_abort got=%0h/%0h exp=0/0", mem_valid, mem_addr); end
    checks++; if (if_ready !== 1'b0 || if_rdata !== 32'h0 || ls_ready !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rm_quiet got=%0h/%0h/%0h/%0h exp=0/0/0/0", if_ready, if_rdata, ls_ready, err); end
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL rm_release got=%0h/%0h exp=0/0", mem_valid, if_ready); end
    tick;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h280) begin failures++; $display("FAIL rm_first got=%0h/%0h exp=1/280", mem_valid, mem_addr); end
    checks++; if (ls_ready !== 1'b1 || if_ready !== 1'b0 || ls_rdata !== 32'hAAAA_5555) begin failures++; $display("FAIL rm_first_ready got=%0h/%0h/%0h exp=1/0/aaaa5555", ls_ready, if_ready, ls_rdata); end
    tick;
    clear_inputs();
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rm_after got=%0h exp=0", mem_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_ls_store();
    test_contention();
    test_withdrawal();
    test_watchdog();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
